alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, registered successor to the 2-bit combinational ALU. Operand width is set by WIDTH.
- Supports the same opcode set and flags. Adds valid/ready handshakes on input and output, and a one-entry output register.
- MODULO is computed by a multi-cycle restoring divider.
- Sits between the operand/decode stage and writeback in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (min 2).
- CNT_W, $clog2(WIDTH+1), width of the divider iteration counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode request valid.
- in_ready  output  1  block can accept a request this cycle.
- a  input  WIDTH  operand A, unsigned/two's-complement.
- b  input  WIDTH  operand B.
- sel  input  4  opcode, using the shared OP_* encodings in ALU_constants.vh.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- out  output  WIDTH  result.
- zero  output  1  out == 0. Forced to 0 when error=1.
- carry  output  1  ADD carry-out / SUB borrow.
- overflow  output  1  signed overflow, ADD/SUB only.
- error  output  1  invalid opcode, or MODULO with b==0.
- busy  output  1  divider iterating.

Behaviour:
- Reset: out_valid, out, zero, carry, overflow, error, busy = 0, divider state cleared. in_ready=0 while rst=1.
- Reset mid-operation aborts any divide and discards any held result.
- in_ready = !busy && (!out_valid || out_ready). This is combinational and allows back-to-back accepts with no bubble.
- Accept: in_valid && in_ready at a rising edge. a, b and sel are captured on that edge.
- Single-cycle ops: result, flags and out_valid=1 are registered on the accept edge (latency 1).
- Results and flags hold stable while out_valid && !out_ready.
- out_valid clears on an out_ready edge unless a new accept occurs on the same edge.
- ADD: {carry,out} = a+b. overflow = a[MSB]==b[MSB] && out[MSB]!=a[MSB].
- SUB: out = a-b mod 2^WIDTH. carry = (a<b) unsigned borrow. overflow = a[MSB]!=b[MSB] && out[MSB]!=a[MSB].
- AND, OR, XOR, NOR, NAND, XNOR: bitwise, carry=overflow=0.
- EQU, GREATER_THAN, LESS_THAN: unsigned compare. out = 1 (zero-extended) if true, else 0. carry=overflow=0.
- MODULO, b!=0:
  - Accept loads remainder=0, dividend=a, count=WIDTH, and sets busy=1. in_ready=0 while busy.
  - Each cycle: rem = {rem,dividend[MSB]}. Subtract b if rem>=b. Shift dividend left. Decrement count.
  - When count reaches 0: out=rem, out_valid=1, busy=0 on the same edge.
  - Latency accept-to-out_valid is WIDTH+1 edges (9 for WIDTH=8). carry=overflow=0.
- MODULO, b==0: single-cycle, out=0, error=1, zero=0, carry=overflow=0.
- Invalid sel (any code not in OP_*, e.g. 4'b1111): single-cycle, out=0, error=1, all other flags 0.
- error=0 for every valid, defined operation.
- Divider states: IDLE -> (accept MODULO, b!=0) -> DIV -> (count==1 edge) -> IDLE with result loaded.
- Divider start is gated by in_ready, so a MODULO result is never overwritten while out_valid && !out_ready.
- out_ready is ignored while out_valid=0.
- in_valid with X operands while in_ready=0 has no effect.

Test Plan:
1. WIDTH=8, ADD a=0x7F b=0x01, out_ready=1 -> 1 cycle later out=0x80, overflow=1, carry=0, zero=0, error=0. Then ADD 0xFF+0x01 -> out=0x00, carry=1, zero=1, overflow=0.
2. SUB a=0x03 b=0x05 -> out=0xFE, carry=1, overflow=0. Then GREATER_THAN 0xFF>0x01 -> out=0x01. Then LESS_THAN 0x02<0x01 -> out=0x00, zero=1.
3. MODULO a=200 b=7:
   - busy=1 and in_ready=0 for 8 cycles.
   - out_valid rises on the 9th edge with out=4, zero=0.
   - A second request held on in_valid during this time is accepted only after completion.
4. MODULO a=5 b=0 -> next edge out=0, error=1, busy never asserts. Then sel=4'b1111 -> error=1, out=0, zero=0.
5. Backpressure: issue AND 0xF0&0x3C with out_ready=0 -> out_valid=1, out=0x30, in_ready=0, values stable for 5 cycles. Raise out_ready with XOR pending -> next result 0xCC accepted on the same edge with no bubble.
6. Assert rst for 1 cycle mid-MODULO (4 cycles in) -> all outputs 0, busy=0, no stale result. A new ADD 1+1 after reset returns 0x02.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered, handshaked ALU. Single-cycle ops land in a one-entry output register;
// MODULO runs a WIDTH-step restoring divider before landing in the same register.
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             error,
   output logic             busy
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_NAND = 4'd6;
   localparam logic [3:0] OP_XNOR = 4'd7;
   localparam logic [3:0] OP_EQU  = 4'd8;
   localparam logic [3:0] OP_GT   = 4'd9;
   localparam logic [3:0] OP_LT   = 4'd10;
   localparam logic [3:0] OP_MOD  = 4'd11;

   typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] out_q, rem_q, dvd_q, dvs_q;
   logic             zero_q, carry_q, ovf_q, err_q, valid_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH-1:0] res_d, rem_d;
   logic             carry_d, ovf_d, err_d, zero_d;
   logic [WIDTH:0]   sum, diff, rem_sh;
   logic             accept, start_div;

   assign in_ready  = !rst && (state_q == S_IDLE) && (!valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign start_div = accept && (sel == OP_MOD) && (b != '0);

   assign out_valid = valid_q;
   assign out       = out_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;
   assign error     = err_q;
   assign busy      = (state_q == S_DIV);

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
      case (sel)
         OP_ADD: begin
            res_d   = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
            ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res_d   = diff[WIDTH-1:0];
            carry_d = diff[WIDTH];
            ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  res_d = a & b;
         OP_OR:   res_d = a | b;
         OP_XOR:  res_d = a ^ b;
         OP_NOR:  res_d = ~(a | b);
         OP_NAND: res_d = ~(a & b);
         OP_XNOR: res_d = ~(a ^ b);
         OP_EQU:  res_d = WIDTH'(a == b);
         OP_GT:   res_d = WIDTH'(a > b);
         OP_LT:   res_d = WIDTH'(a < b);
         // Only the divide-by-zero case resolves here; b!=0 goes to the divider.
         OP_MOD:  err_d = (b == '0);
         default: err_d = 1'b1;
      endcase
      zero_d = (res_d == '0) && !err_d;
   end

   // One restoring step: bring in the next dividend bit, subtract if it fits.
   assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
   always_comb begin
      if (rem_sh >= {1'b0, dvs_q}) rem_d = WIDTH'(rem_sh - {1'b0, dvs_q});
      else                         rem_d = rem_sh[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         valid_q <= 1'b0;
         out_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
      end else begin
         if (valid_q && out_ready) valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_div) begin
                  state_q <= S_DIV;
                  rem_q   <= '0;
                  dvd_q   <= a;
                  dvs_q   <= b;
                  cnt_q   <= CNT_W'(WIDTH);
               end else if (accept) begin
                  valid_q <= 1'b1;
                  out_q   <= res_d;
                  zero_q  <= zero_d;
                  carry_q <= carry_d;
                  ovf_q   <= ovf_d;
                  err_q   <= err_d;
               end
            end
            S_DIV: begin
               rem_q <= rem_d;
               dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= S_IDLE;
                  valid_q <= 1'b1;
                  out_q   <= rem_d;
                  zero_q  <= (rem_d == '0);
                  carry_q <= 1'b0;
                  ovf_q   <= 1'b0;
                  err_q   <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
